// File: rtl/fir_mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_seq_pkg
// Brief    : Q8.8 constants, FSM state type and output saturation helper.
// Revision : 1.0
// ============================================================================
package fir_mac_seq_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Caller sign-extends the accumulator to 64 bits so one helper serves any ACC_W.
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [63:0] acc);
        if (acc > 64'sd32767) begin
            return Q_MAX;
        end else if (acc < -64'sd32768) begin
            return Q_MIN;
        end else begin
            return acc[DATA_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac_seq_mul.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_seq_mul
// Brief    : Q8.8 x Q8.8 -> Q8.8 signed multiplier, truncating, wrapping.
// Revision : 1.0
// ============================================================================
module fir_mac_seq_mul
    import fir_mac_seq_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] p
);

    logic signed [2*DATA_W-1:0] w_full;
    logic                       w_unused;

    assign w_full   = a * b;
    // Dropping the low fraction bits truncates toward -inf; dropping the top wraps.
    assign p        = w_full[DATA_W+FRAC_W-1:FRAC_W];
    assign w_unused = ^{w_full[2*DATA_W-1:DATA_W+FRAC_W], w_full[FRAC_W-1:0]};

endmodule
`default_nettype wire

// File: rtl/fir_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_seq
// Brief    : Sequential FIR stage, one shared Q8.8 multiplier, one tap/clock.
// Revision : 1.0
// ============================================================================
module fir_mac_seq
    import fir_mac_seq_pkg::*;
#(
    parameter int NTAPS = 16,
    parameter int ACC_W = 16 + $clog2(NTAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        x_in,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [DATA_W-1:0]        coef_data,
    input  logic                     clear,
    output logic [DATA_W-1:0]        y_out,
    output logic                     out_valid,
    output logic                     overrun
);

    localparam int IDX_W = $clog2(NTAPS);

    state_t                    r_state;
    state_t                    w_next;
    logic [IDX_W-1:0]          r_idx;
    logic signed [DATA_W-1:0]  r_x [NTAPS];
    logic signed [DATA_W-1:0]  r_h [NTAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DATA_W-1:0]  w_prod;
    logic                      w_accept;
    logic                      w_coef_wr;
    logic                      w_last;

    assign in_ready  = (r_state == ST_IDLE);
    assign w_accept  = in_ready & in_valid;
    assign w_coef_wr = in_ready & ~in_valid & coef_we &
                       ({1'b0, coef_addr} < (IDX_W+1)'(NTAPS));
    assign w_last    = (r_idx == IDX_W'(NTAPS-1));

    fir_mac_seq_mul u_mul (
        .a (r_x[r_idx]),
        .b (r_h[r_idx]),
        .p (w_prod)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = ST_MAC;
            ST_MAC:  if (w_last)   w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_x[k] <= '0;
                r_h[k] <= '0;
            end
            r_acc     <= '0;
            r_idx     <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
            if (in_ready && clear) begin
                overrun <= 1'b0;
                for (int k = 0; k < NTAPS; k++) begin
                    r_x[k] <= '0;
                end
            end
            // A flush coinciding with a new sample leaves only that sample in the line.
            if (w_accept) begin
                r_x[0] <= x_in;
                for (int k = 1; k < NTAPS; k++) begin
                    r_x[k] <= clear ? '0 : r_x[k-1];
                end
                r_acc <= '0;
                r_idx <= '0;
            end
            if (w_coef_wr) begin
                r_h[coef_addr] <= coef_data;
            end
            if (r_state == ST_MAC) begin
                r_acc <= r_acc + {{(ACC_W-DATA_W){w_prod[DATA_W-1]}}, w_prod};
                r_idx <= r_idx + IDX_W'(1);
            end
            if (r_state == ST_DONE) begin
                y_out     <= sat16({{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc});
                out_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_seq
// Brief    : Directed self-checking bench for fir_mac_seq with NTAPS=4.
// Revision : 1.0
// ============================================================================
module tb_fir_mac_seq;

    localparam int NTAPS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_in = '0;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        clear = 1'b0;
    logic [15:0] y_out;
    logic        out_valid;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cset;
        logic        clr;
        logic [15:0] x;
        logic [15:0] y;
    } vec_t;

    vec_t tv [10];

    fir_mac_seq #(.NTAPS(NTAPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .clear     (clear),
        .y_out     (y_out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic write_coefs(input int cset);
        logic [15:0] h [4];
        if (cset == 0) begin
            h[0] = 16'h0100; h[1] = 16'h0080; h[2] = 16'hFFC0; h[3] = 16'h0000;
        end else begin
            h[0] = 16'h0400; h[1] = 16'h0400; h[2] = 16'h0400; h[3] = 16'h0400;
        end
        for (int i = 0; i < NTAPS; i++) begin
            coef_we   = 1'b1;
            coef_addr = 2'(i);
            coef_data = h[i];
            tick();
        end
        coef_we = 1'b0;
    endtask

    // inj>0 offers a sample plus a coefficient write sampled at edge E(inj).
    task automatic run_sample(input string name, input logic [15:0] x, input logic clr,
                              input logic [15:0] exp_y, input int inj);
        int lat    = 0;
        int pulses = 0;
        for (int w = 0; w < 20 && !in_ready; w++) tick();
        in_valid = 1'b1;
        x_in     = x;
        clear    = clr;
        tick();
        in_valid = 1'b0;
        clear    = 1'b0;
        chk({name, " busy"}, {15'd0, in_ready}, 16'd0);
        for (int k = 1; k <= NTAPS + 4; k++) begin
            if (k == inj) begin
                in_valid  = 1'b1;
                x_in      = 16'h7FFF;
                coef_we   = 1'b1;
                coef_addr = 2'd0;
                coef_data = 16'h7000;
            end
            tick();
            if (k == inj) begin
                in_valid = 1'b0;
                coef_we  = 1'b0;
            end
            if (out_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    chk({name, " y"}, y_out, exp_y);
                end
            end
        end
        chk({name, " latency"}, 16'(lat), 16'(NTAPS + 1));
        chk({name, " pulses"}, 16'(pulses), 16'd1);
    endtask

    initial begin
        int prev_set;
        int pulses;

        tv[0] = '{0, 1'b0, 16'h0100, 16'h0100};
        tv[1] = '{0, 1'b0, 16'h0000, 16'h0080};
        tv[2] = '{0, 1'b0, 16'h0000, 16'hFFC0};
        tv[3] = '{0, 1'b0, 16'h0000, 16'h0000};
        tv[4] = '{1, 1'b1, 16'h1000, 16'h4000};
        tv[5] = '{1, 1'b0, 16'h1000, 16'h7FFF};
        tv[6] = '{1, 1'b0, 16'h1000, 16'h7FFF};
        tv[7] = '{1, 1'b1, 16'hF000, 16'hC000};
        tv[8] = '{1, 1'b0, 16'hF000, 16'h8000};
        tv[9] = '{1, 1'b0, 16'hF000, 16'h8000};

        rst = 1'b0;
        tick();
        tick();
        chk("reset in_ready",  {15'd0, in_ready},  16'd1);
        chk("reset out_valid", {15'd0, out_valid}, 16'd0);
        chk("reset y_out",     y_out,              16'h0000);
        chk("reset overrun",   {15'd0, overrun},   16'd0);
        rst = 1'b1;
        tick();

        prev_set = -1;
        for (int i = 0; i < 10; i++) begin
            if (tv[i].cset != prev_set) begin
                write_coefs(tv[i].cset);
                prev_set = tv[i].cset;
            end
            run_sample($sformatf("v%0d", i), tv[i].x, tv[i].clr, tv[i].y, 0);
        end

        // Busy window: dropped sample and ignored coefficient write.
        write_coefs(0);
        run_sample("ovr", 16'h0100, 1'b1, 16'h0100, 2);
        chk("ovr flag", {15'd0, overrun}, 16'd1);
        run_sample("ovr_next", 16'h0100, 1'b0, 16'h0180, 0);
        chk("ovr sticky", {15'd0, overrun}, 16'd1);

        // Flush together with a new sample.
        run_sample("clr", 16'h0100, 1'b1, 16'h0100, 0);
        chk("clr overrun", {15'd0, overrun}, 16'd0);

        // Reset at E2 of a sample.
        for (int w = 0; w < 20 && !in_ready; w++) tick();
        in_valid = 1'b1;
        x_in     = 16'h0100;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rstmac y_out",     y_out,              16'h0000);
        chk("rstmac out_valid", {15'd0, out_valid}, 16'd0);
        chk("rstmac in_ready",  {15'd0, in_ready},  16'd1);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < NTAPS + 4; k++) begin
            tick();
            if (out_valid) pulses++;
        end
        chk("rstmac no pulse", 16'(pulses), 16'd0);
        run_sample("post_rst", 16'h0100, 1'b0, 16'h0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
